// File: rtl/mini_src_pkg.sv
// Shared Mini SRC encodings: opcodes, bus-select codes, sequencer state codes
// and the opcode classifier used by the control sequencer.
package mini_src_pkg;

   localparam logic [4:0] OP_LD   = 5'b00000;
   localparam logic [4:0] OP_LDI  = 5'b00001;
   localparam logic [4:0] OP_ST   = 5'b00010;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_ROR  = 5'b00111;
   localparam logic [4:0] OP_ROL  = 5'b01000;
   localparam logic [4:0] OP_SHR  = 5'b01001;
   localparam logic [4:0] OP_SHRA = 5'b01010;
   localparam logic [4:0] OP_SHL  = 5'b01011;
   localparam logic [4:0] OP_ADDI = 5'b01100;
   localparam logic [4:0] OP_ANDI = 5'b01101;
   localparam logic [4:0] OP_ORI  = 5'b01110;
   localparam logic [4:0] OP_MUL  = 5'b01111;
   localparam logic [4:0] OP_DIV  = 5'b10000;
   localparam logic [4:0] OP_MFHI = 5'b11000;
   localparam logic [4:0] OP_MFLO = 5'b11001;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;

   localparam logic [4:0] SEL_HI    = 5'd16;
   localparam logic [4:0] SEL_LO    = 5'd17;
   localparam logic [4:0] SEL_ZHIGH = 5'd18;
   localparam logic [4:0] SEL_ZLOW  = 5'd19;
   localparam logic [4:0] SEL_PC    = 5'd20;
   localparam logic [4:0] SEL_MDR   = 5'd21;
   localparam logic [4:0] SEL_CSEXT = 5'd22;

   localparam logic [4:0] ALU_NONE = 5'b00000;
   localparam logic [4:0] ALU_ADD  = OP_ADD;

   localparam logic [3:0] ST_IDLE   = 4'd0;
   localparam logic [3:0] ST_F0     = 4'd1;
   localparam logic [3:0] ST_F1     = 4'd2;
   localparam logic [3:0] ST_F2     = 4'd3;
   localparam logic [3:0] ST_T3     = 4'd4;
   localparam logic [3:0] ST_T4     = 4'd5;
   localparam logic [3:0] ST_T5     = 4'd6;
   localparam logic [3:0] ST_T6     = 4'd7;
   localparam logic [3:0] ST_T7     = 4'd8;
   localparam logic [3:0] ST_HALTED = 4'd9;

   typedef enum logic [3:0] {
      CLS_ALU_R,
      CLS_ALU_I,
      CLS_MULDIV,
      CLS_LDI,
      CLS_LD,
      CLS_ST,
      CLS_MFHI,
      CLS_MFLO,
      CLS_NOP,
      CLS_HALT,
      CLS_ILLEGAL
   } opClass_t;

   // Anything not in the supported subset falls through to CLS_ILLEGAL.
   function automatic opClass_t classifyOp(input logic [4:0] op);
      opClass_t cls;
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
         OP_ROL, OP_SHR, OP_SHRA, OP_SHL:   cls = CLS_ALU_R;
         OP_ADDI, OP_ANDI, OP_ORI:          cls = CLS_ALU_I;
         OP_MUL, OP_DIV:                    cls = CLS_MULDIV;
         OP_LDI:                            cls = CLS_LDI;
         OP_LD:                             cls = CLS_LD;
         OP_ST:                             cls = CLS_ST;
         OP_MFHI:                           cls = CLS_MFHI;
         OP_MFLO:                           cls = CLS_MFLO;
         OP_NOP:                            cls = CLS_NOP;
         OP_HALT:                           cls = CLS_HALT;
         default:                           cls = CLS_ILLEGAL;
      endcase
      return cls;
   endfunction

endpackage

// File: rtl/ir_field_decode.sv
// Combinational split of the instruction register into opcode class,
// register indices, the Ra writeback one-hot and the Rb==0 flag.
module ir_field_decode
   import mini_src_pkg::*;
(
   input  logic [31:0] IR,
   output opClass_t    opClass,
   output logic [4:0]  opcode,
   output logic [3:0]  ra,
   output logic [3:0]  rb,
   output logic [3:0]  rc,
   output logic [15:0] raOneHot,
   output logic        rbIsZero
);

   // The low constant bits reach the datapath through Csext, not through here.
   logic unusedImm;

   assign opcode    = IR[31:27];
   assign ra        = IR[26:23];
   assign rb        = IR[22:19];
   assign rc        = IR[18:15];
   assign opClass   = classifyOp(IR[31:27]);
   assign raOneHot  = 16'h0001 << IR[26:23];
   assign rbIsZero  = (IR[22:19] == 4'd0);
   assign unusedImm = ^IR[14:0];

endmodule

// File: rtl/control_sequencer.sv
// Mini SRC control unit: Moore sequencer for fetch / decode / execute that
// drives the datapath bus select, register enables, ALU op and memory strobes.
module control_sequencer
   import mini_src_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic        clock,
   input  logic        clear,
   input  logic        start,
   input  logic [31:0] IR,
   input  logic        mem_ready,
   output logic [4:0]  BusDataSelect,
   output logic [15:0] e_R,
   output logic        e_PC,
   output logic        e_IR,
   output logic        e_Y,
   output logic        e_Z,
   output logic        e_HI,
   output logic        e_LO,
   output logic        e_MAR,
   output logic        e_MDR,
   output logic        incPC,
   output logic        MDR_rd,
   output logic        BAout,
   output logic [4:0]  alu_op,
   output logic        mem_read,
   output logic        mem_write,
   output logic        halted,
   output logic        illegal,
   output logic        mem_err
);

   localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

   logic [3:0]       state;
   logic [3:0]       nextState;
   logic [CNT_W-1:0] waitCnt;
   logic             illegalFlag;
   logic             memErrFlag;
   logic             inWait;
   logic             waitExpired;

   opClass_t    opClass;
   logic [4:0]  opcode;
   logic [3:0]  ra;
   logic [3:0]  rb;
   logic [3:0]  rc;
   logic [15:0] raOneHot;
   logic        rbIsZero;

   ir_field_decode uDecode (
      .IR       (IR),
      .opClass  (opClass),
      .opcode   (opcode),
      .ra       (ra),
      .rb       (rb),
      .rc       (rc),
      .raOneHot (raOneHot),
      .rbIsZero (rbIsZero)
   );

   // States that hold a memory strobe until mem_ready.
   always_comb begin
      inWait = 1'b0;
      case (state)
         ST_F1:   inWait = 1'b1;
         ST_T6:   inWait = (opClass == CLS_LD);
         ST_T7:   inWait = (opClass == CLS_ST);
         default: inWait = 1'b0;
      endcase
   end

   assign waitExpired = inWait && !mem_ready && (waitCnt == CNT_LAST);

   always_comb begin
      nextState = state;
      case (state)
         ST_IDLE: if (start) nextState = ST_F0;
         ST_F0:   nextState = ST_F1;
         ST_F1: begin
            if (mem_ready)        nextState = ST_F2;
            else if (waitExpired) nextState = ST_HALTED;
         end
         ST_F2:   nextState = ST_T3;
         ST_T3: begin
            case (opClass)
               CLS_HALT:                                 nextState = ST_HALTED;
               CLS_MFHI, CLS_MFLO, CLS_NOP, CLS_ILLEGAL: nextState = ST_F0;
               default:                                  nextState = ST_T4;
            endcase
         end
         ST_T4:   nextState = ST_T5;
         ST_T5: begin
            if (opClass == CLS_MULDIV || opClass == CLS_LD || opClass == CLS_ST)
               nextState = ST_T6;
            else
               nextState = ST_F0;
         end
         ST_T6: begin
            if (opClass == CLS_MULDIV)   nextState = ST_F0;
            else if (opClass == CLS_ST)  nextState = ST_T7;
            else if (mem_ready)          nextState = ST_T7;
            else if (waitExpired)        nextState = ST_HALTED;
         end
         ST_T7: begin
            if (opClass == CLS_LD)       nextState = ST_F0;
            else if (mem_ready)          nextState = ST_F0;
            else if (waitExpired)        nextState = ST_HALTED;
         end
         ST_HALTED: nextState = ST_HALTED;
         default:   nextState = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state       <= ST_IDLE;
         waitCnt     <= '0;
         illegalFlag <= 1'b0;
         memErrFlag  <= 1'b0;
      end else begin
         state <= nextState;
         if (inWait && !mem_ready && !waitExpired)
            waitCnt <= waitCnt + 1'b1;
         else
            waitCnt <= '0;
         if (state == ST_T3 && opClass == CLS_ILLEGAL)
            illegalFlag <= 1'b1;
         if (waitExpired)
            memErrFlag <= 1'b1;
      end
   end

   assign halted  = (state == ST_HALTED);
   assign illegal = illegalFlag;
   assign mem_err = memErrFlag;

   // Output decode; e_MDR in a read wait follows mem_ready so MDR captures once.
   always_comb begin
      BusDataSelect = 5'd0;
      e_R           = 16'h0000;
      e_PC          = 1'b0;
      e_IR          = 1'b0;
      e_Y           = 1'b0;
      e_Z           = 1'b0;
      e_HI          = 1'b0;
      e_LO          = 1'b0;
      e_MAR         = 1'b0;
      e_MDR         = 1'b0;
      incPC         = 1'b0;
      MDR_rd        = 1'b0;
      BAout         = 1'b0;
      alu_op        = ALU_NONE;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      case (state)
         ST_F0: begin
            BusDataSelect = SEL_PC;
            e_MAR         = 1'b1;
            incPC         = 1'b1;
         end
         ST_F1: begin
            mem_read = 1'b1;
            MDR_rd   = 1'b1;
            e_MDR    = mem_ready;
         end
         ST_F2: begin
            BusDataSelect = SEL_MDR;
            e_IR          = 1'b1;
         end
         ST_T3: begin
            case (opClass)
               CLS_ALU_R, CLS_ALU_I: begin
                  BusDataSelect = {1'b0, rb};
                  e_Y           = 1'b1;
               end
               CLS_MULDIV: begin
                  BusDataSelect = {1'b0, ra};
                  e_Y           = 1'b1;
               end
               CLS_LDI, CLS_LD, CLS_ST: begin
                  BusDataSelect = {1'b0, rb};
                  e_Y           = 1'b1;
                  BAout         = rbIsZero;
               end
               CLS_MFHI: begin
                  BusDataSelect = SEL_HI;
                  e_R           = raOneHot;
               end
               CLS_MFLO: begin
                  BusDataSelect = SEL_LO;
                  e_R           = raOneHot;
               end
               default: ;
            endcase
         end
         ST_T4: begin
            case (opClass)
               CLS_ALU_R: begin
                  BusDataSelect = {1'b0, rc};
                  alu_op        = opcode;
                  e_Z           = 1'b1;
               end
               CLS_ALU_I: begin
                  BusDataSelect = SEL_CSEXT;
                  alu_op        = opcode;
                  e_Z           = 1'b1;
               end
               CLS_MULDIV: begin
                  BusDataSelect = {1'b0, rb};
                  alu_op        = opcode;
                  e_Z           = 1'b1;
               end
               CLS_LDI, CLS_LD, CLS_ST: begin
                  BusDataSelect = SEL_CSEXT;
                  alu_op        = ALU_ADD;
                  e_Z           = 1'b1;
               end
               default: ;
            endcase
         end
         ST_T5: begin
            case (opClass)
               CLS_ALU_R, CLS_ALU_I, CLS_LDI: begin
                  BusDataSelect = SEL_ZLOW;
                  e_R           = raOneHot;
               end
               CLS_MULDIV: begin
                  BusDataSelect = SEL_ZLOW;
                  e_LO          = 1'b1;
               end
               CLS_LD, CLS_ST: begin
                  BusDataSelect = SEL_ZLOW;
                  e_MAR         = 1'b1;
               end
               default: ;
            endcase
         end
         ST_T6: begin
            case (opClass)
               CLS_MULDIV: begin
                  BusDataSelect = SEL_ZHIGH;
                  e_HI          = 1'b1;
               end
               CLS_LD: begin
                  mem_read = 1'b1;
                  MDR_rd   = 1'b1;
                  e_MDR    = mem_ready;
               end
               CLS_ST: begin
                  BusDataSelect = {1'b0, ra};
                  e_MDR         = 1'b1;
               end
               default: ;
            endcase
         end
         ST_T7: begin
            case (opClass)
               CLS_LD: begin
                  BusDataSelect = SEL_MDR;
                  e_R           = raOneHot;
               end
               CLS_ST:  mem_write = 1'b1;
               default: ;
            endcase
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: directed instruction sequences push
// expected output vectors, a negedge monitor pops and compares them.
module tb_control_sequencer;

   typedef struct packed {
      logic [4:0]  sel;
      logic [15:0] eR;
      logic        ePC;
      logic        eIR;
      logic        eY;
      logic        eZ;
      logic        eHI;
      logic        eLO;
      logic        eMAR;
      logic        eMDR;
      logic        incPC;
      logic        mdrRd;
      logic        baOut;
      logic [4:0]  alu;
      logic        rd;
      logic        wr;
      logic        hlt;
      logic        ill;
      logic        merr;
   } outs_t;

   logic        clk = 1'b0;
   logic        clear;
   logic        start;
   logic        memReady;
   logic [31:0] IR;

   logic [4:0]  bds  [2];
   logic [15:0] eR   [2];
   logic        ePC  [2];
   logic        eIR  [2];
   logic        eY   [2];
   logic        eZ   [2];
   logic        eHI  [2];
   logic        eLO  [2];
   logic        eMAR [2];
   logic        eMDR [2];
   logic        inc  [2];
   logic        mdr  [2];
   logic        ba   [2];
   logic [4:0]  alu  [2];
   logic        rd   [2];
   logic        wr   [2];
   logic        hlt  [2];
   logic        ill  [2];
   logic        merr [2];
   outs_t       obs  [2];

   outs_t expQ0 [$];
   outs_t expQ1 [$];
   string nameQ0 [$];
   string nameQ1 [$];
   int    checks = 0;
   int    errors = 0;
   logic  expIll = 1'b0;

   always #5 clk = ~clk;

   control_sequencer dut (
      .clock(clk), .clear(clear), .start(start), .IR(IR), .mem_ready(memReady),
      .BusDataSelect(bds[0]), .e_R(eR[0]), .e_PC(ePC[0]), .e_IR(eIR[0]), .e_Y(eY[0]),
      .e_Z(eZ[0]), .e_HI(eHI[0]), .e_LO(eLO[0]), .e_MAR(eMAR[0]), .e_MDR(eMDR[0]),
      .incPC(inc[0]), .MDR_rd(mdr[0]), .BAout(ba[0]), .alu_op(alu[0]),
      .mem_read(rd[0]), .mem_write(wr[0]), .halted(hlt[0]), .illegal(ill[0]), .mem_err(merr[0])
   );

   // Short-timeout copy sharing every input; it must give up on the 5-cycle store.
   control_sequencer #(.MEM_TIMEOUT(4)) dutTo (
      .clock(clk), .clear(clear), .start(start), .IR(IR), .mem_ready(memReady),
      .BusDataSelect(bds[1]), .e_R(eR[1]), .e_PC(ePC[1]), .e_IR(eIR[1]), .e_Y(eY[1]),
      .e_Z(eZ[1]), .e_HI(eHI[1]), .e_LO(eLO[1]), .e_MAR(eMAR[1]), .e_MDR(eMDR[1]),
      .incPC(inc[1]), .MDR_rd(mdr[1]), .BAout(ba[1]), .alu_op(alu[1]),
      .mem_read(rd[1]), .mem_write(wr[1]), .halted(hlt[1]), .illegal(ill[1]), .mem_err(merr[1])
   );

   assign obs[0] = {bds[0], eR[0], ePC[0], eIR[0], eY[0], eZ[0], eHI[0], eLO[0], eMAR[0], eMDR[0],
                    inc[0], mdr[0], ba[0], alu[0], rd[0], wr[0], hlt[0], ill[0], merr[0]};
   assign obs[1] = {bds[1], eR[1], ePC[1], eIR[1], eY[1], eZ[1], eHI[1], eLO[1], eMAR[1], eMDR[1],
                    inc[1], mdr[1], ba[1], alu[1], rd[1], wr[1], hlt[1], ill[1], merr[1]};

   task automatic compareOne(input string tag, input outs_t got, input outs_t want, input string nm);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s %s: got %h required %h", tag, nm, got, want);
      end
   endtask

   always @(negedge clk) begin
      if (expQ0.size() > 0) compareOne("dut", obs[0], expQ0.pop_front(), nameQ0.pop_front());
      if (expQ1.size() > 0) compareOne("dutTo", obs[1], expQ1.pop_front(), nameQ1.pop_front());
   end

   function automatic outs_t blank();
      outs_t r;
      r     = '0;
      r.ill = expIll;
      return r;
   endfunction

   function automatic logic [31:0] mkIR(input logic [4:0] op, input logic [3:0] ra,
                                        input logic [3:0] rb, input logic [18:0] low);
      return {op, ra, rb, low};
   endfunction

   task automatic step(input string nm, input outs_t e);
      nameQ0.push_back(nm);
      expQ0.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic expectTo(input string nm, input outs_t e);
      nameQ1.push_back(nm);
      expQ1.push_back(e);
   endtask

   task automatic fetch(input logic [31:0] ir, input int waits, input string tag);
      outs_t e;
      IR       = ir;
      start    = 1'b0;
      memReady = 1'b0;
      e = blank(); e.sel = 5'd20; e.eMAR = 1'b1; e.incPC = 1'b1;
      step({tag, ".F0"}, e);
      for (int i = 0; i < waits; i++) begin
         e = blank(); e.rd = 1'b1; e.mdrRd = 1'b1;
         step({tag, ".F1wait"}, e);
      end
      memReady = 1'b1;
      e = blank(); e.rd = 1'b1; e.mdrRd = 1'b1; e.eMDR = 1'b1;
      step({tag, ".F1rdy"}, e);
      memReady = 1'b0;
      e = blank(); e.sel = 5'd21; e.eIR = 1'b1;
      step({tag, ".F2"}, e);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no summary, required finish within time limit");
      $fatal(1);
   end

   initial begin
      outs_t e;
      clear    = 1'b0;
      start    = 1'b0;
      memReady = 1'b0;
      IR       = 32'h0;
      @(posedge clk);
      #1;
      e = blank(); expectTo("rst0", e); step("rst0", e);
      e = blank(); expectTo("rst1", e); step("rst1", e);

      // add R3,R1,R2 with three memory wait cycles in fetch
      clear = 1'b1;
      start = 1'b1;
      IR    = 32'h19890000;
      e = blank(); step("idleStart", e);
      fetch(32'h19890000, 3, "add");
      e = blank(); e.sel = 5'd1; e.eY = 1'b1; step("add.T3", e);
      e = blank(); e.sel = 5'd2; e.alu = 5'b00011; e.eZ = 1'b1; step("add.T4", e);
      e = blank(); e.sel = 5'd19; e.eR = 16'h0008; step("add.T5", e);

      // mul R4,R5
      fetch(mkIR(5'b01111, 4'd4, 4'd5, 19'd0), 0, "mul");
      e = blank(); e.sel = 5'd4; e.eY = 1'b1; step("mul.T3", e);
      e = blank(); e.sel = 5'd5; e.alu = 5'b01111; e.eZ = 1'b1; step("mul.T4", e);
      e = blank(); e.sel = 5'd19; e.eLO = 1'b1; step("mul.T5", e);
      e = blank(); e.sel = 5'd18; e.eHI = 1'b1; step("mul.T6", e);

      // ld R1,0x20(R0)
      fetch(mkIR(5'b00000, 4'd1, 4'd0, 19'h20), 1, "ld");
      e = blank(); e.sel = 5'd0; e.eY = 1'b1; e.baOut = 1'b1; step("ld.T3", e);
      e = blank(); e.sel = 5'd22; e.alu = 5'b00011; e.eZ = 1'b1; step("ld.T4", e);
      e = blank(); e.sel = 5'd19; e.eMAR = 1'b1; step("ld.T5", e);
      for (int i = 0; i < 2; i++) begin
         e = blank(); e.rd = 1'b1; e.mdrRd = 1'b1; step("ld.T6wait", e);
      end
      memReady = 1'b1;
      e = blank(); e.rd = 1'b1; e.mdrRd = 1'b1; e.eMDR = 1'b1; step("ld.T6rdy", e);
      memReady = 1'b0;
      e = blank(); e.sel = 5'd21; e.eR = 16'h0002; step("ld.T7", e);

      // ldi R2,5(R3): nonzero base, no BAout
      fetch(mkIR(5'b00001, 4'd2, 4'd3, 19'd5), 0, "ldi");
      e = blank(); e.sel = 5'd3; e.eY = 1'b1; step("ldi.T3", e);
      e = blank(); e.sel = 5'd22; e.alu = 5'b00011; e.eZ = 1'b1; step("ldi.T4", e);
      e = blank(); e.sel = 5'd19; e.eR = 16'h0004; step("ldi.T5", e);

      // andi R0,R7,0xFF: R0 is a normal writeback target
      fetch(mkIR(5'b01101, 4'd0, 4'd7, 19'hFF), 0, "andi");
      e = blank(); e.sel = 5'd7; e.eY = 1'b1; step("andi.T3", e);
      e = blank(); e.sel = 5'd22; e.alu = 5'b01101; e.eZ = 1'b1; step("andi.T4", e);
      e = blank(); e.sel = 5'd19; e.eR = 16'h0001; step("andi.T5", e);

      // st 0x10(R6),R9: stray mem_ready in T4-T6 must be ignored
      fetch(mkIR(5'b00010, 4'd9, 4'd6, 19'h10), 2, "st");
      e = blank(); e.sel = 5'd6; e.eY = 1'b1; step("st.T3", e);
      memReady = 1'b1;
      e = blank(); e.sel = 5'd22; e.alu = 5'b00011; e.eZ = 1'b1; step("st.T4", e);
      e = blank(); e.sel = 5'd19; e.eMAR = 1'b1; step("st.T5", e);
      e = blank(); e.sel = 5'd9; e.eMDR = 1'b1; step("st.T6", e);
      memReady = 1'b0;
      for (int i = 0; i < 4; i++) begin
         e = blank(); e.wr = 1'b1;
         if (i == 3) expectTo("st.T7lastWait", e);
         step("st.T7wait", e);
      end
      memReady = 1'b1;
      e = blank(); e.hlt = 1'b1; e.merr = 1'b1; expectTo("timeoutHalt", e);
      e = blank(); e.wr = 1'b1; step("st.T7rdy", e);
      memReady = 1'b0;

      // nop, while the short-timeout copy stays halted
      e = blank(); e.hlt = 1'b1; e.merr = 1'b1; expectTo("timeoutHold", e);
      fetch(mkIR(5'b11010, 4'd0, 4'd0, 19'd0), 0, "nop");
      e = blank(); step("nop.T3", e);

      // unlisted opcode 11111 behaves as nop and sets the sticky flag
      fetch(mkIR(5'b11111, 4'd5, 4'd5, 19'd0), 0, "ill");
      e = blank(); step("ill.T3", e);
      expIll = 1'b1;

      // halt: start is ignored afterwards
      fetch(mkIR(5'b11011, 4'd0, 4'd0, 19'd0), 1, "halt");
      e = blank(); step("halt.T3", e);
      start = 1'b1;
      e = blank(); e.hlt = 1'b1; step("halted", e);
      e = blank(); e.hlt = 1'b1; step("haltedStart", e);
      start = 1'b0;

      // clear recovers both sequencers and drops the sticky flags
      clear  = 1'b0;
      expIll = 1'b0;
      e = blank(); expectTo("clearHalted", e); step("clearHalted", e);
      clear = 1'b1;
      start = 1'b1;
      e = blank(); step("idleStart2", e);

      // sub R1,R2,R3 aborted by clear in the middle of T4
      fetch(mkIR(5'b00100, 4'd1, 4'd2, {4'd3, 15'd0}), 0, "sub");
      e = blank(); e.sel = 5'd2; e.eY = 1'b1; step("sub.T3", e);
      clear = 1'b0;
      e = blank(); expectTo("clearMidT4", e); step("clearMidT4", e);
      e = blank(); step("clearHold", e);

      @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
